// File: rtl/logic_unit_sweeper_if.sv
// Sweeper bus: start/status toward the controller, A/B/sel/Y toward the logic unit under drive.
interface logic_unit_sweeper_if;
   logic       start;
   logic       y_i;
   logic       a_o;
   logic       b_o;
   logic       sel_o;
   logic       busy;
   logic       done;
   logic [7:0] result_vec;
   logic [3:0] err_cnt;

   modport master (
      input  start, y_i,
      output a_o, b_o, sel_o, busy, done, result_vec, err_cnt
   );

   modport slave (
      output start, y_i,
      input  a_o, b_o, sel_o, busy, done, result_vec, err_cnt
   );
endinterface

// File: rtl/logic_unit_sweeper.sv
// Steps an OR/NOR logic unit through all 8 {sel,A,B} vectors and captures Y; SWEEP_CHECK_EN adds the mismatch counter.
// Latency: done 8*(SETTLE_CYCLES+1)+1 cycles after start is accepted; start is ignored unless IDLE (no backpressure).
module logic_unit_sweeper #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   logic_unit_sweeper_if.master io_bus
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_SAMPLE = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   logic [1:0] r_state;
   logic [2:0] r_idx;
   logic [3:0] r_settle_cnt;
   logic       r_busy;
   logic       r_done;
   logic [7:0] r_result_vec;
   logic       w_accept;

   assign w_accept = (r_state == ST_IDLE) && io_bus.start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_idx        <= 3'd0;
         r_settle_cnt <= 4'd0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_result_vec <= 8'h00;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (io_bus.start) begin
                  r_idx        <= 3'd0;
                  r_settle_cnt <= 4'd0;
                  r_result_vec <= 8'h00;
                  r_busy       <= 1'b1;
                  r_state      <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (r_settle_cnt == SETTLE_LAST) begin
                  r_settle_cnt <= 4'd0;
                  r_state      <= ST_SAMPLE;
               end else begin
                  r_settle_cnt <= r_settle_cnt + 4'd1;
               end
            end
            ST_SAMPLE: begin
               r_result_vec[r_idx] <= io_bus.y_i;
               if (r_idx == 3'd7) begin
                  // done is registered here so it is high for exactly the DONE cycle
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_idx   <= r_idx + 3'd1;
                  r_state <= ST_SETTLE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef SWEEP_CHECK_EN
   logic [3:0] r_err_cnt;
   logic       w_exp;

   assign w_exp = r_idx[2] ? ~(r_idx[1] | r_idx[0]) : (r_idx[1] | r_idx[0]);

   // At most one increment per vector, so the count tops out at 8 without wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_cnt <= 4'd0;
      end else if (w_accept) begin
         r_err_cnt <= 4'd0;
      end else if ((r_state == ST_SAMPLE) && (io_bus.y_i != w_exp)) begin
         r_err_cnt <= r_err_cnt + 4'd1;
      end
   end

   assign io_bus.err_cnt = r_err_cnt;
`else
   assign io_bus.err_cnt = 4'd0;
`endif

   assign io_bus.sel_o      = r_idx[2];
   assign io_bus.a_o        = r_idx[1];
   assign io_bus.b_o        = r_idx[0];
   assign io_bus.busy       = r_busy;
   assign io_bus.done       = r_done;
   assign io_bus.result_vec = r_result_vec;

endmodule

// File: tb/tb_logic_unit_sweeper.sv
// Bench for logic_unit_sweeper: two instances (settle 2 and settle 1) checked against a cycle-count model.
module tb_logic_unit_sweeper;

`ifdef SWEEP_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic [1:0] st;
   int   mode[2];

   int n_cmp = 0;
   int n_err = 0;

   logic_unit_sweeper_if u_if0 ();
   logic_unit_sweeper_if u_if1 ();

   // Correct OR/NOR unit behaviour, then the fault variants the bench can plug in
   function automatic logic yfun(input int m, input logic [2:0] v);
      logic c;
      c = v[2] ? ~(v[1] | v[0]) : (v[1] | v[0]);
      case (m)
         1:       return 1'b0;
         2:       return ~c;
         default: return c;
      endcase
   endfunction

   assign u_if0.start = st[0];
   assign u_if1.start = st[1];
   assign u_if0.y_i   = yfun(mode[0], {u_if0.sel_o, u_if0.a_o, u_if0.b_o});
   assign u_if1.y_i   = yfun(mode[1], {u_if1.sel_o, u_if1.a_o, u_if1.b_o});

   logic_unit_sweeper #(.SETTLE_CYCLES(2)) u_dut0 (.clk(clk), .rst_n(rst_n), .io_bus(u_if0.master));
   logic_unit_sweeper #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .io_bus(u_if1.master));

   logic [2:0] o_vec[2];
   logic       o_busy[2];
   logic       o_done[2];
   logic [7:0] o_res[2];
   logic [3:0] o_err[2];

   assign o_vec[0]  = {u_if0.sel_o, u_if0.a_o, u_if0.b_o};
   assign o_vec[1]  = {u_if1.sel_o, u_if1.a_o, u_if1.b_o};
   assign o_busy[0] = u_if0.busy;
   assign o_busy[1] = u_if1.busy;
   assign o_done[0] = u_if0.done;
   assign o_done[1] = u_if1.done;
   assign o_res[0]  = u_if0.result_vec;
   assign o_res[1]  = u_if1.result_vec;
   assign o_err[0]  = u_if0.err_cnt;
   assign o_err[1]  = u_if1.err_cnt;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
      end
   endtask

   function automatic int settle_of(input int i);
      return (i == 0) ? 2 : 1;
   endfunction

   // Model: m_k = cycles since start was accepted (0 = idle). Vector v occupies cycles
   // v*P+1 .. (v+1)*P with P = settle+1, sampled in its last cycle; done in cycle 8P+1.
   int         m_k[2];
   logic [2:0] m_vec[2];
   logic [7:0] m_res[2];
   int         m_errc[2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         m_k[i] = 0; m_vec[i] = 3'd0; m_res[i] = 8'h00; m_errc[i] = 0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            m_k[i] = 0; m_vec[i] = 3'd0; m_res[i] = 8'h00; m_errc[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            int p;
            logic [2:0] v;
            logic y;
            p = settle_of(i) + 1;
            if (m_k[i] == 0) begin
               if (st[i]) begin
                  m_k[i] = 1; m_vec[i] = 3'd0; m_res[i] = 8'h00; m_errc[i] = 0;
               end
            end else begin
               if (m_k[i] <= 8 * p && (m_k[i] % p) == 0) begin
                  v = 3'((m_k[i] - 1) / p);
                  y = yfun(mode[i], v);
                  m_res[i][v] = y;
                  if (CHK && (y != yfun(0, v))) m_errc[i] = m_errc[i] + 1;
               end
               if (m_k[i] == 8 * p + 1) begin
                  m_k[i] = 0;
               end else begin
                  m_k[i] = m_k[i] + 1;
                  if (m_k[i] <= 8 * p) m_vec[i] = 3'((m_k[i] - 1) / p);
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk("busy", i, 32'(o_busy[i]), 32'(m_k[i] != 0));
         chk("done", i, 32'(o_done[i]), 32'(m_k[i] == 8 * (settle_of(i) + 1) + 1));
         chk("vec",  i, 32'(o_vec[i]),  32'(m_vec[i]));
         chk("res",  i, 32'(o_res[i]),  32'(m_res[i]));
         chk("err",  i, 32'(o_err[i]),  32'(m_errc[i]));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Start a sweep on instance d, optionally re-pulse start at cycles p1/p2, return the done cycle
   task automatic run_sweep(input int d, input int p1, input int p2, output int dcyc);
      int c;
      st[d] = 1'b1;
      tick();
      st[d] = 1'b0;
      c = 1;
      chk("busy_c1", d, 32'(o_busy[d]), 32'd1);
      chk("clr_res", d, 32'(o_res[d]), 32'h00);
      chk("clr_err", d, 32'(o_err[d]), 32'd0);
      while (!o_done[d] && c < 200) begin
         st[d] = (c == p1 || c == p2);
         tick();
         c++;
      end
      st[d] = 1'b0;
      if (!o_done[d]) chk("done_timeout", d, 32'd0, 32'd1);
      dcyc = c;
      tick();
   endtask

   initial begin
      int dc;
      int npulse;
      rst_n = 1'b1;
      st = 2'b00;
      mode[0] = 0;
      mode[1] = 0;
      #2 rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst_res",  0, 32'(o_res[0]),  32'h00);
      chk("rst_busy", 0, 32'(o_busy[0]), 32'd0);
      chk("rst_vec",  0, 32'(o_vec[0]),  32'd0);

      // correct unit
      run_sweep(0, -1, -1, dc);
      chk("s1_done_cyc", 0, 32'(dc), 32'd25);
      chk("s1_res", 0, 32'(o_res[0]), 32'h1E);
      chk("s1_err", 0, 32'(o_err[0]), 32'd0);
      chk("s1_vec_hold", 0, 32'(o_vec[0]), 32'd7);

      // Y stuck at 0
      mode[0] = 1;
      run_sweep(0, -1, -1, dc);
      chk("s2_res", 0, 32'(o_res[0]), 32'h00);
      chk("s2_err", 0, 32'(o_err[0]), CHK ? 32'd4 : 32'd0);

      // inverted unit
      mode[0] = 2;
      run_sweep(0, -1, -1, dc);
      chk("s3_res", 0, 32'(o_res[0]), 32'hE1);
      chk("s3_err", 0, 32'(o_err[0]), CHK ? 32'd8 : 32'd0);

      // extra start pulses during vectors 3 and 7 are ignored
      mode[0] = 0;
      run_sweep(0, 10, 22, dc);
      chk("s4_done_cyc", 0, 32'(dc), 32'd25);
      chk("s4_res", 0, 32'(o_res[0]), 32'h1E);

      // reset during SETTLE of vector 5 (cycles 16..18)
      st[0] = 1'b1;
      tick();
      st[0] = 1'b0;
      for (int c = 1; c < 16; c++) tick();
      chk("s5_vec_pre", 0, 32'(o_vec[0]), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("s5_vec", 0, 32'(o_vec[0]), 32'd0);
      chk("s5_busy", 0, 32'(o_busy[0]), 32'd0);
      chk("s5_res", 0, 32'(o_res[0]), 32'h00);
      chk("s5_err", 0, 32'(o_err[0]), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      run_sweep(0, -1, -1, dc);
      chk("s5b_done_cyc", 0, 32'(dc), 32'd25);
      chk("s5b_res", 0, 32'(o_res[0]), 32'h1E);

      // start held high: back-to-back sweeps
      npulse = 0;
      st[0] = 1'b1;
      for (int c = 0; c < 70; c++) begin
         if (c == 40) st[0] = 1'b0;
         tick();
         if (o_done[0]) npulse++;
      end
      chk("s6_pulses", 0, 32'(npulse), 32'd2);

      // settle of one cycle
      run_sweep(1, -1, -1, dc);
      chk("s7_done_cyc", 1, 32'(dc), 32'd17);
      chk("s7_res", 1, 32'(o_res[1]), 32'h1E);

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/logic_unit_sweeper.md
Name: logic_unit_sweeper

Overview:
Upstream stimulus and result-capture stage for the selectable OR/NOR logic unit.
- On a start pulse, it steps the unit's A, B and sel inputs through all 8 combinations.
- After a programmable settle time, it samples the unit's Y output.
- It packs the 8 samples into a result vector and, optionally, counts mismatches against the expected OR/NOR function.
- A single sweep engine drives each logic-unit instance in self-test builds.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before Y is sampled; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE
y_i  input  1  Y output of the logic unit under drive
a_o  output  1  A input to the logic unit
b_o  output  1  B input to the logic unit
sel_o  output  1  sel input to the logic unit
busy  output  1  high from the cycle after start is accepted until DONE is exited
done  output  1  one-cycle pulse when the sweep completes
result_vec  output  8  bit i = sampled Y for vector index i = {sel,A,B}
err_cnt  output  4  number of mismatching vectors in the last sweep (0..8)

Behaviour:
- Reset is asynchronous and active-low, with one clock domain.
- While rst_n=0, every register clears immediately:
  - state=IDLE, idx=0, settle_cnt=0
  - a_o=b_o=sel_o=0, busy=0, done=0, result_vec=8'h00, err_cnt=0
- Reset asserted mid-sweep aborts the sweep with no done pulse. Operation resumes in IDLE after rst_n is deasserted.
- Vector index idx[2:0]: sel_o=idx[2], a_o=idx[1], b_o=idx[0]. The outputs derive directly from the registered idx and are glitch-free.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: outputs hold their last values and busy=0. When start=1:
  - idx<=0, settle_cnt<=0
  - result_vec<=0, err_cnt<=0
  - busy<=1, go to SETTLE
- SETTLE: settle_cnt increments each cycle. When settle_cnt==SETTLE_CYCLES-1, reset settle_cnt to 0 and go to SAMPLE.
- SAMPLE: result_vec[idx]<=y_i, and err_cnt updates per the optional feature.
  - If idx==7, go to DONE.
  - Otherwise idx<=idx+1 and return to SETTLE.
- DONE: done=1 for exactly this cycle, busy<=0, next state IDLE. idx stays 7, so outputs stay at vector 7 until the next start.
- Timing:
  - Each vector is driven for SETTLE_CYCLES+1 cycles and sampled in its last cycle.
  - done is high in cycle 8*(SETTLE_CYCLES+1)+1 after the start-accept edge. This is cycle 25 for the default.
- start while busy, or in DONE, is ignored with no restart and no effect on results.
- start held high continuously causes one sweep, then another begins on the first IDLE cycle.
- Expected value: exp = sel ? ~(A|B) : (A|B). For a correct unit, result_vec=8'h1E.
- err_cnt saturates at 8 by construction and never wraps.
- result_vec and err_cnt remain stable after DONE until the next accepted start or reset.

Optional Feature:
SWEEP_CHECK_EN:
- Defined: in SAMPLE, if y_i != exp for the current idx, err_cnt<=err_cnt+1.
- Undefined: no compare logic is built and err_cnt is tied to 4'd0. result_vec capture is unchanged.

Test Plan:
- Correct OR/NOR unit connected, SETTLE_CYCLES=2, pulse start → busy high next cycle; a_o/b_o/sel_o step through 000..111, each held 3 cycles; done pulses 25 cycles after start; result_vec=8'h1E; err_cnt=0.
- Y stuck at 0 with SWEEP_CHECK_EN defined → result_vec=8'h00, err_cnt=4. The same stimulus with the macro undefined → err_cnt=0.
- Y driven as ~correct → result_vec=8'hE1, err_cnt=8. Then a second start → result_vec and err_cnt clear to 0 on the accepting edge before new capture.
- start pulsed again at vectors 3 and 7 during a sweep → no restart; done still at cycle 25; results identical to the first scenario.
- rst_n pulled low during SETTLE of vector 5 → outputs, busy, result_vec and err_cnt are 0 immediately; no done pulse. After rst_n=1 and start, a full sweep completes normally.
- SETTLE_CYCLES=1 → each vector is held 2 cycles; done at cycle 17; result_vec=8'h1E.
